// File: rtl/fft_input_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_input_loader_if
//  Description : Sample-stream and frame-bus bundle between an upstream
//                sample source, the FFT input loader and the FFT input
//                register file.
//                  IN_VALID/IN_READY/IN_r/IN_i : complex sample stream
//                  BUSY                        : FFT core still working
//                  OUT_r/OUT_i                 : 32-slot frame bus, slot k
//                                                at [k*W +: W]
//                  OUT_VALID                   : one-cycle load strobe
//                  FRAME_CNT                   : frames emitted, mod 256
//                Modports: master = source/consumer side, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_input_loader_if #(
    parameter int W = 30
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [W-1:0]      IN_r;
    logic [W-1:0]      IN_i;
    logic              BUSY;
    logic [32*W-1:0]   OUT_r;
    logic [32*W-1:0]   OUT_i;
    logic              OUT_VALID;
    logic [7:0]        FRAME_CNT;

    modport master (
        output IN_VALID, IN_r, IN_i, BUSY,
        input  IN_READY, OUT_r, OUT_i, OUT_VALID, FRAME_CNT
    );

    modport slave (
        input  IN_VALID, IN_r, IN_i, BUSY,
        output IN_READY, OUT_r, OUT_i, OUT_VALID, FRAME_CNT
    );
endinterface
`default_nettype wire

// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fft_input_loader
//  Description : Collects 32 complex Q(I.F) samples from a valid/ready stream
//                into a slot buffer and strobes OUT_VALID for one cycle once
//                the frame is complete and the FFT core is not BUSY.
//                Ports:
//                  CLK  - clock, rising edge
//                  RST  - synchronous active-high reset
//                  bus  - fft_input_loader_if.slave (stream in, frame out)
//                Build option:
//                  FFT_IN_BITREV_EN defined   -> sample n lands in slot
//                                                bitrev5(n)
//                  FFT_IN_BITREV_EN undefined -> sample n lands in slot n
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_input_loader #(
    parameter int I = 19,
    parameter int F = 11
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    fft_input_loader_if.slave  bus
);
    localparam int W = I + F;
    localparam int N = 32;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FULL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [N*W-1:0]   r_out_r;
    logic [N*W-1:0]   r_out_i;
    logic [7:0]       r_frame_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [4:0]       w_slot;
    logic             w_accept;

`ifdef FFT_IN_BITREV_EN
    // Bit-reversed placement feeds the in-place DIT core directly.
    assign w_slot = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3], r_cnt[4]};
`else
    assign w_slot = r_cnt;
`endif

    // r_in_ready is high exactly while in S_FILL, so it doubles as the
    // state qualifier for acceptance.
    assign w_accept = bus.IN_VALID & r_in_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_FILL;
            r_cnt       <= 5'd0;
            r_out_r     <= '0;
            r_out_i     <= '0;
            r_frame_cnt <= 8'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_out_r[int'(w_slot)*W +: W] <= bus.IN_r;
                        r_out_i[int'(w_slot)*W +: W] <= bus.IN_i;
                        // 5-bit counter wraps 31 -> 0 on the frame's last sample.
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state    <= S_FULL;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (!bus.BUSY) begin
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    r_state     <= S_FILL;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                default: begin
                    r_state     <= S_FILL;
                    r_cnt       <= 5'd0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.IN_READY  = r_in_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_r     = r_out_r;
    assign bus.OUT_i     = r_out_i;
    assign bus.FRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_input_loader
//  Description : Self-checking bench for fft_input_loader. A frame-level
//                reference model (array of expected slots, accept counter,
//                frame counter) predicts handshake, strobe and bus contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_loader;
    localparam int W = 30;

    logic clk;
    logic rst;

    fft_input_loader_if #(.W(W)) bus ();

    fft_input_loader #(.I(19), .F(11)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_r [32];
    logic [W-1:0] m_i [32];
    int  m_count;      // samples accepted in current frame
    bit  m_full;       // frame complete, waiting for core
    bit  m_emit;       // strobe expected this cycle
    int  m_frames;
    bit  m_acc;        // sample accepted at the last edge
    int  cyc = 0;
    int  acc_cyc = 0;
    int  last_pulse = -1;

    function automatic int slot_of(input int n);
        int s;
`ifdef FFT_IN_BITREV_EN
        s = 0;
        for (int b = 0; b < 5; b++)
            if (((n >> b) & 1) == 1) s += 1 << (4 - b);
`else
        s = n;
`endif
        return s;
    endfunction

    function automatic logic [63:0] hash_bus(input logic [32*W-1:0] vr, input logic [32*W-1:0] vi);
        logic [63:0] h;
        h = 64'd0;
        for (int k = 0; k < 32; k++) begin
            h = (h * 64'd1000003) ^ {34'd0, vr[k*W +: W]};
            h = (h * 64'd1000003) ^ {34'd0, vi[k*W +: W]};
        end
        return h;
    endfunction

    function automatic logic [63:0] hash_model();
        logic [32*W-1:0] vr;
        logic [32*W-1:0] vi;
        for (int k = 0; k < 32; k++) begin
            vr[k*W +: W] = m_r[k];
            vi[k*W +: W] = m_i[k];
        end
        return hash_bus(vr, vi);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            m_r[k] = '0;
            m_i[k] = '0;
        end
        m_count  = 0;
        m_full   = 0;
        m_emit   = 0;
        m_frames = 0;
    endtask

    task automatic model_edge();
        m_acc = 0;
        cyc++;
        if (rst) begin
            model_clear();
        end else if (m_emit) begin
            m_emit   = 0;
            m_frames = (m_frames + 1) % 256;
        end else if (m_full) begin
            if (!bus.BUSY) begin
                m_full = 0;
                m_emit = 1;
            end
        end else if (bus.IN_VALID) begin
            m_r[slot_of(m_count)] = bus.IN_r;
            m_i[slot_of(m_count)] = bus.IN_i;
            m_acc = 1;
            m_count++;
            if (m_count == 32) begin
                m_count = 0;
                m_full  = 1;
                acc_cyc = cyc;
            end
        end
    endtask

    task automatic compare();
        check_eq("in_ready", 64'(bus.IN_READY), 64'(!m_full && !m_emit));
        check_eq("out_valid", 64'(bus.OUT_VALID), 64'(m_emit));
        check_eq("frame_cnt", 64'(bus.FRAME_CNT), 64'(m_frames));
        check_eq("bus_hash", hash_bus(bus.OUT_r, bus.OUT_i), hash_model());
        if (bus.OUT_VALID === 1'b1) begin
            if (last_pulse >= 0)
                check_eq("pulse_gap_ge_33", 64'((cyc - last_pulse) >= 33), 64'd1);
            last_pulse = cyc;
        end
        if (m_emit) begin
            for (int k = 0; k < 32; k++) begin
                check_eq($sformatf("slot_r[%0d]", k), 64'(bus.OUT_r[k*W +: W]), 64'(m_r[k]));
                check_eq($sformatf("slot_i[%0d]", k), 64'(bus.OUT_i[k*W +: W]), 64'(m_i[k]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load_sample(input bit pattern, input int n);
        if (pattern) begin
            bus.IN_r = W'(n << 11);
            bus.IN_i = W'(-(n << 11));
        end else begin
            bus.IN_r = W'($urandom);
            bus.IN_i = W'($urandom);
        end
    endtask

    // Presents samples until nsamp have been accepted; the pending sample is
    // held until the loader takes it.
    task automatic run_samples(input int nsamp, input int gap_pct, input bit pattern);
        int got;
        int budget;
        got = 0;
        budget = 0;
        while (got < nsamp && budget < 400) begin
            bus.IN_VALID = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            step();
            if (m_acc) begin
                got++;
                load_sample(pattern, got);
            end
            budget++;
        end
        if (got < nsamp) check_eq("accept_timeout", 64'(got), 64'(nsamp));
    endtask

    task automatic wait_pulse(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (bus.OUT_VALID !== 1'b1 && waited < 60);
        if (bus.OUT_VALID !== 1'b1) check_eq("pulse_timeout", 64'd0, 64'd1);
    endtask

    int waited;

    initial begin
        rst = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.BUSY = 1'b0;
        bus.IN_r = '0;
        bus.IN_i = '0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        check_eq("reset_out_r_zero", 64'(bus.OUT_r == '0), 64'd1);
        check_eq("reset_out_i_zero", 64'(bus.OUT_i == '0), 64'd1);

        // Back-to-back ramp frame.
        load_sample(1'b1, 0);
        run_samples(32, 0, 1'b1);
        bus.IN_VALID = 1'b0;
        wait_pulse(waited);
        check_eq("load_latency", 64'(cyc - acc_cyc + 1), 64'd2);
`ifdef FFT_IN_BITREV_EN
        check_eq("slot16_r", 64'(bus.OUT_r[16*W +: W]), 64'h800);
        check_eq("slot24_r", 64'(bus.OUT_r[24*W +: W]), 64'h1800);
`else
        check_eq("slot16_r", 64'(bus.OUT_r[16*W +: W]), 64'h8000);
        check_eq("slot24_r", 64'(bus.OUT_r[24*W +: W]), 64'hC000);
`endif
        check_eq("slot31_r", 64'(bus.OUT_r[31*W +: W]), 64'hF800);
        check_eq("slot31_i", 64'(bus.OUT_i[31*W +: W]), 64'h3FFF0800);
        step();
        check_eq("frame_cnt_one", 64'(bus.FRAME_CNT), 64'd1);

        // BUSY held 10 cycles after fill, IN_VALID high throughout.
        bus.BUSY = 1'b1;
        load_sample(1'b0, 0);
        run_samples(32, 0, 1'b0);
        repeat (10) step();
        bus.BUSY = 1'b0;
        wait_pulse(waited);
        check_eq("busy_release_latency", 64'(waited), 64'd1);
        run_samples(32, 0, 1'b0);   // held sample must be first of next frame
        bus.IN_VALID = 1'b0;
        wait_pulse(waited);

        // Random gaps with the ramp pattern.
        load_sample(1'b1, 0);
        run_samples(32, 50, 1'b1);
        bus.IN_VALID = 1'b0;
        wait_pulse(waited);
        step();

        // Reset mid-frame after 17 samples.
        load_sample(1'b0, 0);
        run_samples(17, 0, 1'b0);
        bus.IN_VALID = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midreset_out_r_zero", 64'(bus.OUT_r == '0), 64'd1);
        check_eq("midreset_out_i_zero", 64'(bus.OUT_i == '0), 64'd1);
        load_sample(1'b1, 0);
        run_samples(32, 0, 1'b1);
        bus.IN_VALID = 1'b0;
        wait_pulse(waited);
        check_eq("post_reset_latency", 64'(cyc - acc_cyc + 1), 64'd2);

        // Long streaming run: FRAME_CNT wraps.
        load_sample(1'b0, 0);
        for (int f = 0; f < 258; f++) begin
            run_samples(32, 0, 1'b0);
            wait_pulse(waited);
            if (m_frames == 255) begin
                step();
                check_eq("frame_cnt_wrap", 64'(bus.FRAME_CNT), 64'd0);
            end
        end
        bus.IN_VALID = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
